// File: rtl/div_ctrl_if.sv
// Bundle between the EX-stage divide controller, the pipeline and the divider.
// The slave modport is the controller's view; master is the surrounding pipeline/divider.
interface div_ctrl_if;
  // Pipeline side
  logic        ex_div_i;
  logic        ex_signed_i;
  logic [31:0] ex_op1_i;
  logic [31:0] ex_op2_i;
  logic        flush_i;
  logic        stall_req_o;
  // Divider side
  logic        div_start_o;
  logic        div_annul_o;
  logic        div_signed_o;
  logic [31:0] div_op1_o;
  logic [31:0] div_op2_o;
  logic [63:0] div_result_i;
  logic        div_finish_i;
  // HI/LO write port and status
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_err_o;

  modport slave (
    input  ex_div_i, ex_signed_i, ex_op1_i, ex_op2_i, flush_i, div_result_i, div_finish_i,
    output stall_req_o, div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    output hilo_we_o, hi_o, lo_o, div_err_o
  );

  modport master (
    output ex_div_i, ex_signed_i, ex_op1_i, ex_op2_i, flush_i, div_result_i, div_finish_i,
    input  stall_req_o, div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o,
    input  hilo_we_o, hi_o, lo_o, div_err_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencing controller for the multi-cycle EX-stage divider: holds operands, stalls the
// pipeline while the divider runs, commits HI/LO once, annuls on flush, and has a watchdog.
module div_ctrl #(
  parameter int unsigned MAX_CYCLES = 48
) (
  input logic       clk,
  input logic       rst,
  div_ctrl_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StRelease, StFlush} state_e;

  // Counter holds (BUSY cycle number - 1), so this value marks the last allowed cycle.
  localparam logic [5:0] WdLast = 6'(MAX_CYCLES - 1);

  state_e      state_q, state_d;
  logic        flush_cnt_q, flush_cnt_d;
  logic [5:0]  wd_cnt_q, wd_cnt_d;
  logic        err_q, err_d;
  logic        signed_q, signed_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;

  logic        stall, start, annul, we, timeout;
  logic [31:0] hi, lo;

  // State, operand, watchdog and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      flush_cnt_q <= 1'b0;
      wd_cnt_q    <= '0;
      err_q       <= 1'b0;
      signed_q    <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      err_q       <= err_d;
      signed_q    <= signed_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    err_d       = err_q;
    signed_d    = signed_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    stall       = 1'b0;
    start       = 1'b0;
    annul       = 1'b0;
    we          = 1'b0;
    timeout     = 1'b0;
    hi          = '0;
    lo          = '0;

    unique case (state_q)
      StIdle: begin
        // Gate with rst so nothing is requested while reset is held
        if (bus.ex_div_i && !bus.flush_i && !rst) begin
          op1_d    = bus.ex_op1_i;
          op2_d    = bus.ex_op2_i;
          signed_d = bus.ex_signed_i;
          wd_cnt_d = '0;
          stall    = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        start    = 1'b1;
        stall    = 1'b1;
        wd_cnt_d = wd_cnt_q + 6'd1;
        if (bus.flush_i) begin
          // Flush wins over a finish in the same cycle: the result is discarded
          stall       = 1'b0;
          flush_cnt_d = 1'b0;
          state_d     = StFlush;
        end else if (bus.div_finish_i) begin
          stall   = 1'b0;
          we      = 1'b1;
          hi      = bus.div_result_i[63:32];
          lo      = bus.div_result_i[31:0];
          state_d = StRelease;
        end else if (wd_cnt_q == WdLast) begin
          stall       = 1'b0;
          timeout     = 1'b1;
          err_d       = 1'b1;
          flush_cnt_d = 1'b0;
          state_d     = StFlush;
        end
      end
      StRelease: begin
        // Dropping start returns the divider to idle; a waiting divide stays stalled
        stall   = bus.ex_div_i;
        state_d = StIdle;
      end
      StFlush: begin
        annul = 1'b1;
        if (flush_cnt_q) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.stall_req_o  = stall;
  assign bus.div_start_o  = start;
  assign bus.div_annul_o  = annul;
  assign bus.div_signed_o = signed_q;
  assign bus.div_op1_o    = op1_q;
  assign bus.div_op2_o    = op2_q;
  assign bus.hilo_we_o    = we;
  assign bus.hi_o         = hi;
  assign bus.lo_o         = lo;
  // Error is visible already in the cycle the watchdog expires
  assign bus.div_err_o    = err_q | timeout;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural divider model, scoreboard queue of expected
// HI/LO writes, directed cases plus randomized divides, flushes and back-to-back requests.
module tb_div_ctrl;

  localparam int MAX_CYCLES = 48;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl #(.MAX_CYCLES(MAX_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  // Divider model configuration, set by the stimulus per request
  int m_lat  = 1;
  bit m_hang = 1'b0;
  int m_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference divide: MIPS semantics (truncate toward zero), divide by zero yields 0
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint qa, qb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
    end else begin
      qa = longint'({32'd0, a});
      qb = longint'({32'd0, b});
    end
    q = qa / qb;
    r = qa % qb;
    return {r[31:0], q[31:0]};
  endfunction

  // Divider model: finishes after m_lat cycles of start, returns to idle on start low/annul
  always @(posedge clk) begin
    #1;
    if (rst || !bus.div_start_o || bus.div_annul_o) begin
      m_cnt            = 0;
      bus.div_finish_i = 1'b0;
      bus.div_result_i = 64'd0;
    end else begin
      m_cnt++;
      if (!m_hang && m_cnt >= m_lat) begin
        bus.div_finish_i = 1'b1;
        bus.div_result_i = ref_div(bus.div_op1_o, bus.div_op2_o, bus.div_signed_o);
      end
    end
  end

  // Monitor: every HI/LO write must match the oldest expected result
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.hilo_we_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_write actual=%h required=no_write (t=%0t)",
                   {bus.hi_o, bus.lo_o}, $time);
        end else begin
          chk("hilo_write", {bus.hi_o, bus.lo_o}, exp_q.pop_front());
          chk("write_stall_low", bus.stall_req_o, 1'b0);
        end
      end else begin
        chk("hilo_zero_idle", {bus.hi_o, bus.lo_o}, 64'd0);
      end
    end
  end

  task automatic post_flush();
    @(posedge clk); #1;
    bus.flush_i  = 1'b0;
    bus.ex_div_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("flush_annul", bus.div_annul_o, 1'b1);
      chk("flush_start", bus.div_start_o, 1'b0);
      chk("flush_stall", bus.stall_req_o, 1'b0);
      chk("flush_no_write", bus.hilo_we_o, 1'b0);
    end
    @(negedge clk);
    chk("flush_done_annul", bus.div_annul_o, 1'b0);
  endtask

  // One request issued while the controller is idle; flush_at = BUSY cycle to flush (0 = none)
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] req, input int lat, input int flush_at,
                        input bit hang, input bit hold, input logic [31:0] na,
                        input logic [31:0] nb, input logic ns);
    bit done;
    @(posedge clk); #1;
    bus.ex_div_i    = 1'b1;
    bus.ex_signed_i = s;
    bus.ex_op1_i    = a;
    bus.ex_op2_i    = b;
    bus.flush_i     = 1'b0;
    m_lat           = lat;
    m_hang          = hang;
    if (!hang && flush_at == 0) exp_q.push_back(req);
    @(negedge clk);
    chk("accept_stall", bus.stall_req_o, 1'b1);
    chk("accept_no_start", bus.div_start_o, 1'b0);
    done = 1'b0;
    for (int c = 1; c <= MAX_CYCLES + 4 && !done; c++) begin
      @(posedge clk); #1;
      // Operands wiggle while busy; the controller must ignore them
      bus.ex_op1_i    = $urandom;
      bus.ex_op2_i    = $urandom;
      bus.ex_signed_i = 1'($urandom_range(0, 1));
      bus.flush_i     = (c == flush_at);
      @(negedge clk);
      chk("busy_start", bus.div_start_o, 1'b1);
      chk("busy_annul", bus.div_annul_o, 1'b0);
      chk("op_frozen", {bus.div_signed_o, bus.div_op1_o, bus.div_op2_o}, {31'd0, s, a, b});
      if (c == flush_at) begin
        chk("flushed_no_write", bus.hilo_we_o, 1'b0);
        post_flush();
        done = 1'b1;
      end else if (hang && c == MAX_CYCLES) begin
        chk("wd_err_set", bus.div_err_o, 1'b1);
        chk("wd_no_write", bus.hilo_we_o, 1'b0);
        post_flush();
        chk("wd_err_sticky", bus.div_err_o, 1'b1);
        done = 1'b1;
      end else if (bus.hilo_we_o) begin
        chk("write_cycle", 64'(c), 64'(lat));
        @(posedge clk); #1;
        bus.ex_div_i = hold;
        if (hold) begin
          bus.ex_signed_i = ns;
          bus.ex_op1_i    = na;
          bus.ex_op2_i    = nb;
        end
        @(negedge clk);
        chk("release_start_low", bus.div_start_o, 1'b0);
        chk("release_stall", bus.stall_req_o, 64'(hold));
        done = 1'b1;
      end else begin
        chk("busy_stall", bus.stall_req_o, 1'b1);
        if (hang) chk("wd_err_pending", bus.div_err_o, 1'b0);
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL no_completion actual=busy required=done (t=%0t)", $time);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] ca, cb, na, nb;
    logic cs, ns;
    int lat, fl;
    bit hold;

    bus.ex_div_i     = 1'b0;
    bus.ex_signed_i  = 1'b0;
    bus.ex_op1_i     = 32'd0;
    bus.ex_op2_i     = 32'd0;
    bus.flush_i      = 1'b0;
    bus.div_finish_i = 1'b0;
    bus.div_result_i = 64'd0;

    // Reset state, including a request raised while reset is held
    repeat (2) @(posedge clk);
    #1;
    bus.ex_div_i = 1'b1;
    bus.ex_op1_i = 32'h1234_5678;
    @(negedge clk);
    chk("rst_outputs", {bus.stall_req_o, bus.div_start_o, bus.div_annul_o, bus.hilo_we_o,
                        bus.div_err_o, bus.div_signed_o}, 64'd0);
    chk("rst_ops", {bus.div_op1_o, bus.div_op2_o}, 64'd0);
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    @(posedge clk); #1;
    bus.ex_div_i = 1'b0;
    rst = 1'b0;

    // Directed cases with hand-derived results
    do_div(32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, 8, 0, 0, 0, 0, 0, 0);
    do_div(32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 5, 0, 0, 0, 0, 0, 0);
    do_div(32'hFFFFFFFF, 32'h10, 1'b0, 64'h0000000F_0FFFFFFF, 3, 0, 0, 0, 0, 0, 0);
    do_div(32'd5, 32'd0, 1'b1, 64'd0, 4, 0, 0, 0, 0, 0, 0);
    do_div(32'd1234, 32'd5, 1'b0, 64'd0, 30, 10, 0, 0, 0, 0, 0);
    do_div(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 6, 0, 0, 0, 0, 0, 0);
    do_div(32'd20, 32'd6, 1'b1, 64'h00000002_00000003, 7, 0, 0, 1, 32'd21, 32'd4, 1'b1);
    do_div(32'd21, 32'd4, 1'b1, 64'h00000001_00000005, 9, 0, 0, 0, 0, 0, 0);
    // Flush in the same cycle the divider finishes: no write
    do_div(32'd77, 32'd3, 1'b0, 64'd0, 12, 12, 0, 0, 0, 0, 0);

    // Randomized divides, occasional flushes and back-to-back chains
    ca = $urandom;
    cb = $urandom_range(1, 1000);
    cs = 1'b1;
    for (int i = 0; i < 25; i++) begin
      na = $urandom;
      case ($urandom_range(0, 7))
        0:       nb = 32'd0;
        1, 2:    nb = $urandom_range(1, 50);
        3:       nb = -($urandom_range(1, 50));
        default: nb = $urandom;
      endcase
      ns   = 1'($urandom_range(0, 1));
      lat  = $urandom_range(1, 20);
      fl   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
      hold = 1'($urandom_range(0, 1));
      do_div(ca, cb, cs, ref_div(ca, cb, cs), lat, fl, 0, hold, na, nb, ns);
      ca = na;
      cb = nb;
      cs = ns;
    end

    // Hung divider: watchdog fires, error stays set across a later good divide
    do_div(32'd50, 32'd5, 1'b0, 64'd0, 0, 0, 1, 0, 0, 0, 0);
    do_div(32'd64, 32'd8, 1'b0, 64'h00000000_00000008, 2, 0, 0, 0, 0, 0, 0);
    chk("err_sticky_after_ok", bus.div_err_o, 1'b1);

    // Reset in the middle of a divide returns to idle and clears the error
    @(posedge clk); #1;
    m_hang       = 1'b1;
    bus.ex_div_i = 1'b1;
    bus.ex_op1_i = 32'd99;
    bus.ex_op2_i = 32'd9;
    @(posedge clk); #1;
    bus.ex_div_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_outputs", {bus.stall_req_o, bus.div_start_o, bus.div_annul_o, bus.div_err_o},
        64'd0);
    chk("midrst_ops", {bus.div_op1_o, bus.div_op2_o}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_div(32'd99, 32'd9, 1'b0, 64'h00000000_0000000B, 5, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
